codificador_nivel_reservatorio: RTL and testbench

//  Upstream stage of the level display. Samples 7 reservoir level probes, synchronises and debounces them,

---
 rtl/codificador_nivel_reservatorio.sv | 145 ++++++++++++++
 tb/tb_codificador_nivel_reservatorio.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/codificador_nivel_reservatorio.sv
// Reservoir level encoder: synchronises and debounces 7 level probes, checks the
// thermometer pattern and encodes it into a 3-bit level for the row driver.
// Optional feature: define NIVEL_RAMPA_EN to slew nivel by at most one step per
// encoder evaluation instead of loading the target level directly.
module codificador_nivel_reservatorio #(
    parameter int DIV               = 50000,
    parameter int DEBOUNCE_AMOSTRAS = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] sensores,
    output logic [2:0] nivel,
    output logic       nivel_valido,
    output logic       erro_sensor,
    output logic       mudou
);

    localparam int            DW      = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [DW-1:0] DIV_MAX = DW'(DIV - 1);
    localparam logic [3:0]    CNT_MAX = 4'(DEBOUNCE_AMOSTRAS - 1);

    logic [6:0]      meta;
    logic [6:0]      sinc;
    logic [6:0]      deb;
    logic [6:0]      deb_prox;
    logic [6:0][3:0] cnt;
    logic [6:0][3:0] cnt_prox;
    logic [DW-1:0]   div_cnt;
    logic            tick;
    logic            tick_q;
    logic            padrao_ok;
    logic [2:0]      alvo;
    logic [2:0]      nivel_prox;

    assign tick = (div_cnt == DIV_MAX);

    // Two-flop synchroniser for the asynchronous probe inputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= '0;
            sinc <= '0;
        end else begin
            meta <= sensores;
            sinc <= meta;
        end
    end

    // Free-running sample divider; tick_q marks the encoder evaluation cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
            tick_q  <= 1'b0;
        end else begin
            if (tick) begin
                div_cnt <= '0;
            end else begin
                div_cnt <= div_cnt + DW'(1);
            end
            tick_q <= tick;
        end
    end

    // Per-bit debounce: accept a new value after enough consecutive differing ticks.
    always_comb begin
        deb_prox = deb;
        cnt_prox = cnt;
        for (int i = 0; i < 7; i++) begin
            if (sinc[i] == deb[i]) begin
                cnt_prox[i] = '0;
            end else if (cnt[i] == CNT_MAX) begin
                deb_prox[i] = sinc[i];
                cnt_prox[i] = '0;
            end else begin
                cnt_prox[i] = cnt[i] + 4'd1;
            end
        end
    end

    // Debounced vector and counters advance only on a sample tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            deb <= '0;
            cnt <= '0;
        end else if (tick) begin
            deb <= deb_prox;
            cnt <= cnt_prox;
        end
    end

    // Thermometer decode of the debounced vector into the target level.
    always_comb begin
        padrao_ok = 1'b1;
        alvo      = 3'd0;
        case (deb)
            7'b0000000: alvo = 3'd0;
            7'b0000001: alvo = 3'd1;
            7'b0000011: alvo = 3'd2;
            7'b0000111: alvo = 3'd3;
            7'b0001111: alvo = 3'd4;
            7'b0011111: alvo = 3'd5;
            7'b0111111: alvo = 3'd6;
            7'b1111111: alvo = 3'd7;
            default:    padrao_ok = 1'b0;
        endcase
    end

    // Next level: either a direct load or a one-step slew toward the target.
    always_comb begin
`ifdef NIVEL_RAMPA_EN
        if (alvo > nivel) begin
            nivel_prox = nivel + 3'd1;
        end else if (alvo < nivel) begin
            nivel_prox = nivel - 3'd1;
        end else begin
            nivel_prox = nivel;
        end
`else
        nivel_prox = alvo;
`endif
    end

    // Registered encoder outputs; a bad pattern holds the last good level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nivel        <= 3'd0;
            nivel_valido <= 1'b0;
            erro_sensor  <= 1'b0;
            mudou        <= 1'b0;
        end else begin
            mudou <= 1'b0;
            if (tick_q) begin
                if (padrao_ok) begin
                    erro_sensor  <= 1'b0;
                    nivel_valido <= 1'b1;
                    nivel        <= nivel_prox;
                    mudou        <= (nivel_prox != nivel);
                end else begin
                    erro_sensor  <= 1'b1;
                    nivel_valido <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_codificador_nivel_reservatorio.sv
// Self-checking bench for codificador_nivel_reservatorio (DIV=4, DEBOUNCE_AMOSTRAS=3).
// A behavioural model tracks probe acceptance from the sample-tick rules; directed
// scenarios add fixed expectations on top of the cycle-by-cycle model comparison.
module tb_codificador_nivel_reservatorio;

    localparam int DIV = 4;
    localparam int DEB = 3;

    logic       clk;
    logic       rst_n;
    logic [6:0] sensores;
    logic [2:0] nivel;
    logic       nivel_valido;
    logic       erro_sensor;
    logic       mudou;

    int total = 0;
    int bad   = 0;

    codificador_nivel_reservatorio #(
        .DIV               (DIV),
        .DEBOUNCE_AMOSTRAS (DEB)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .sensores     (sensores),
        .nivel        (nivel),
        .nivel_valido (nivel_valido),
        .erro_sensor  (erro_sensor),
        .mudou        (mudou)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural reference model ----------------
    logic [6:0] m_s1, m_s2, m_deb;
    int         m_run [7];
    int         m_div;
    bit         m_tq;
    logic [2:0] m_nivel;
    logic       m_val, m_err, m_mud;

    function automatic int wet_count(input logic [6:0] v);
        int n = 0;
        for (int i = 0; i < 7; i++) n += int'(v[i]);
        return n;
    endfunction

    function automatic bit is_thermo(input logic [6:0] v);
        for (int k = 0; k <= 7; k++) begin
            if (int'(v) == ((1 << k) - 1)) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic logic [2:0] next_level(input logic [2:0] cur, input int target);
`ifdef NIVEL_RAMPA_EN
        if (target > int'(cur)) return cur + 3'd1;
        if (target < int'(cur)) return cur - 3'd1;
        return cur;
`else
        return 3'(target);
`endif
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_s1 <= '0; m_s2 <= '0; m_deb <= '0;
            for (int i = 0; i < 7; i++) m_run[i] <= 0;
            m_div <= 0; m_tq <= 1'b0;
            m_nivel <= 3'd0; m_val <= 1'b0; m_err <= 1'b0; m_mud <= 1'b0;
        end else begin
            m_s1  <= sensores;
            m_s2  <= m_s1;
            m_div <= (m_div == DIV - 1) ? 0 : m_div + 1;
            m_tq  <= (m_div == DIV - 1);
            if (m_div == DIV - 1) begin
                for (int i = 0; i < 7; i++) begin
                    if (m_s2[i] == m_deb[i]) begin
                        m_run[i] <= 0;
                    end else if (m_run[i] + 1 >= DEB) begin
                        m_deb[i] <= m_s2[i];
                        m_run[i] <= 0;
                    end else begin
                        m_run[i] <= m_run[i] + 1;
                    end
                end
            end
            m_mud <= 1'b0;
            if (m_tq) begin
                if (!is_thermo(m_deb)) begin
                    m_err <= 1'b1;
                    m_val <= 1'b0;
                end else begin
                    m_err   <= 1'b0;
                    m_val   <= 1'b1;
                    m_nivel <= next_level(m_nivel, wet_count(m_deb));
                    m_mud   <= (next_level(m_nivel, wet_count(m_deb)) != m_nivel);
                end
            end
        end
    end

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_n    = 1'b0;
        sensores = 7'b0;
        repeat (3) @(negedge clk);
        total++;
        if ({nivel, nivel_valido, erro_sensor, mudou} !== 6'b0) begin
            bad++;
            $display("FAIL reset_outputs: got %b required %b",
                     {nivel, nivel_valido, erro_sensor, mudou}, 6'b0);
        end
        rst_n = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            total++;
            if ({nivel, nivel_valido, erro_sensor, mudou} !== {m_nivel, m_val, m_err, m_mud}) begin
                bad++;
                $display("FAIL reset_model cyc%0d: got %b required %b", i,
                         {nivel, nivel_valido, erro_sensor, mudou},
                         {m_nivel, m_val, m_err, m_mud});
            end
            total++;
            if ({nivel, nivel_valido, erro_sensor, mudou} !== {3'd0, (i >= 5), 1'b0, 1'b0}) begin
                bad++;
                $display("FAIL reset_first_valid cyc%0d: got %b required %b", i,
                         {nivel, nivel_valido, erro_sensor, mudou},
                         {3'd0, (i >= 5), 1'b0, 1'b0});
            end
        end
    endtask

    task automatic test_level3();
        int pulses = 0;
        int reached = 0;
        sensores = 7'b0000111;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            pulses += int'(mudou);
            if (nivel === 3'd3 && reached == 0) reached = i;
            total++;
            if ({nivel, nivel_valido, erro_sensor, mudou} !== {m_nivel, m_val, m_err, m_mud}) begin
                bad++;
                $display("FAIL level3_model cyc%0d: got %b required %b", i,
                         {nivel, nivel_valido, erro_sensor, mudou},
                         {m_nivel, m_val, m_err, m_mud});
            end
        end
        total++;
        if (reached == 0 || reached > 2 + 3 * 4 + 1) begin
            bad++;
            $display("FAIL level3_latency: got cycle %0d required 1..15", reached);
        end
        total++;
        if (pulses != 1) begin
            bad++;
            $display("FAIL level3_pulses: got %0d required 1", pulses);
        end
    endtask

    task automatic test_glitch();
        int pulses = 0;
        sensores = 7'b0001111;
        repeat (8) @(negedge clk);
        sensores = 7'b0000111;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            pulses += int'(mudou);
            total++;
            if ({nivel, nivel_valido, erro_sensor, mudou} !== {m_nivel, m_val, m_err, m_mud}) begin
                bad++;
                $display("FAIL glitch_model cyc%0d: got %b required %b", i,
                         {nivel, nivel_valido, erro_sensor, mudou},
                         {m_nivel, m_val, m_err, m_mud});
            end
        end
        total++;
        if (nivel !== 3'd3 || pulses != 0) begin
            bad++;
            $display("FAIL glitch_hold: got nivel=%0d pulses=%0d required nivel=3 pulses=0",
                     nivel, pulses);
        end
    endtask

    task automatic test_fault();
        sensores = 7'b0000101;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            total++;
            if ({nivel, nivel_valido, erro_sensor, mudou} !== {m_nivel, m_val, m_err, m_mud}) begin
                bad++;
                $display("FAIL fault_model cyc%0d: got %b required %b", i,
                         {nivel, nivel_valido, erro_sensor, mudou},
                         {m_nivel, m_val, m_err, m_mud});
            end
        end
        total++;
        if ({nivel, nivel_valido, erro_sensor} !== {3'd3, 1'b0, 1'b1}) begin
            bad++;
            $display("FAIL fault_flag: got %b required %b",
                     {nivel, nivel_valido, erro_sensor}, {3'd3, 1'b0, 1'b1});
        end
        sensores = 7'b0001111;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            total++;
            if ({nivel, nivel_valido, erro_sensor, mudou} !== {m_nivel, m_val, m_err, m_mud}) begin
                bad++;
                $display("FAIL recover_model cyc%0d: got %b required %b", i,
                         {nivel, nivel_valido, erro_sensor, mudou},
                         {m_nivel, m_val, m_err, m_mud});
            end
        end
        total++;
        if ({nivel, nivel_valido, erro_sensor} !== {3'd4, 1'b1, 1'b0}) begin
            bad++;
            $display("FAIL fault_recover: got %b required %b",
                     {nivel, nivel_valido, erro_sensor}, {3'd4, 1'b1, 1'b0});
        end
    endtask

    task automatic test_ramp();
        int pulses = 0;
`ifdef NIVEL_RAMPA_EN
        int want = 6;
`else
        int want = 1;
`endif
        sensores = 7'b0;
        repeat (40) @(negedge clk);
        total++;
        if (nivel !== 3'd0) begin
            bad++;
            $display("FAIL ramp_start: got %0d required 0", nivel);
        end
        sensores = 7'b0111111;
        for (int i = 1; i <= 50; i++) begin
            @(negedge clk);
            pulses += int'(mudou);
            total++;
            if ({nivel, nivel_valido, erro_sensor, mudou} !== {m_nivel, m_val, m_err, m_mud}) begin
                bad++;
                $display("FAIL ramp_model cyc%0d: got %b required %b", i,
                         {nivel, nivel_valido, erro_sensor, mudou},
                         {m_nivel, m_val, m_err, m_mud});
            end
        end
        total++;
        if (nivel !== 3'd6 || pulses != want) begin
            bad++;
            $display("FAIL ramp_end: got nivel=%0d pulses=%0d required nivel=6 pulses=%0d",
                     nivel, pulses, want);
        end
    endtask

    task automatic test_reset_mid();
        sensores = 7'b0011111;
        repeat (40) @(negedge clk);
        total++;
        if (nivel !== 3'd5) begin
            bad++;
            $display("FAIL mid_level5: got %0d required 5", nivel);
        end
        sensores = 7'b0000011;
        repeat (7) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        total++;
        if ({nivel, nivel_valido, erro_sensor, mudou} !== 6'b0) begin
            bad++;
            $display("FAIL mid_reset_outputs: got %b required %b",
                     {nivel, nivel_valido, erro_sensor, mudou}, 6'b0);
        end
        sensores = 7'b0011111;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            total++;
            if ({nivel, nivel_valido, erro_sensor, mudou} !== {m_nivel, m_val, m_err, m_mud}) begin
                bad++;
                $display("FAIL mid_model cyc%0d: got %b required %b", i,
                         {nivel, nivel_valido, erro_sensor, mudou},
                         {m_nivel, m_val, m_err, m_mud});
            end
        end
        total++;
        if ({nivel, nivel_valido, erro_sensor} !== {3'd5, 1'b1, 1'b0}) begin
            bad++;
            $display("FAIL mid_reacquire: got %b required %b",
                     {nivel, nivel_valido, erro_sensor}, {3'd5, 1'b1, 1'b0});
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 300; n++) begin
            int k = int'($urandom_range(0, 7));
            int hold = int'($urandom_range(1, 20));
            logic [6:0] pat;
            pat = 7'((1 << k) - 1);
            if ($urandom_range(0, 3) == 0) pat = 7'($urandom);
            sensores = pat;
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                total++;
                if ({nivel, nivel_valido, erro_sensor, mudou} !==
                    {m_nivel, m_val, m_err, m_mud}) begin
                    bad++;
                    $display("FAIL random_model step%0d: got %b required %b", n,
                             {nivel, nivel_valido, erro_sensor, mudou},
                             {m_nivel, m_val, m_err, m_mud});
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_level3();
        test_glitch();
        test_fault();
        test_ramp();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
